// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the MIPS front end:
// opcode/funct constants, PC FSM states and redirect kinds.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_BR   = 2'd1,
    K_JMP  = 2'd2,
    K_JR   = 2'd3
  } kind_e;

endpackage

// File: rtl/pc_redirect_decode.sv
// Combinational redirect decode for the ID stage:
// picks JR, then J/JAL, then taken BEQ.
module pc_redirect_decode #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [5:0]  OP_BEQ   = cpu_defs_pkg::OP_BEQ,
  parameter logic [5:0]  OP_J     = cpu_defs_pkg::OP_J,
  parameter logic [5:0]  OP_JAL   = cpu_defs_pkg::OP_JAL,
  parameter logic [5:0]  OP_RTYPE = cpu_defs_pkg::OP_RTYPE,
  parameter logic [5:0]  FUNCT_JR = cpu_defs_pkg::FUNCT_JR
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic [WIDTH-1:0]   branch_target,
  input  logic [WIDTH-1:0]   jump_target,
  input  logic [WIDTH-1:0]   reg_target,
  output cpu_defs_pkg::kind_e kind,
  output logic               redirect,
  output logic [WIDTH-1:0]   target
);
  import cpu_defs_pkg::*;

  logic is_jr;
  logic is_jmp;
  logic is_br;

  assign is_jr  = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
  assign is_jmp = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_br  = (opcode == OP_BEQ) && zero;

  // Priority select of redirect kind and target
  always_comb begin
    kind     = K_NONE;
    redirect = 1'b0;
    target   = branch_target;
    if (is_jr) begin
      kind     = K_JR;
      redirect = 1'b1;
      target   = reg_target;
    end else if (is_jmp) begin
      kind     = K_JMP;
      redirect = 1'b1;
      target   = jump_target;
    end else if (is_br) begin
      kind     = K_BR;
      redirect = 1'b1;
      target   = branch_target;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Registered PC with redirect, stall hold,
// deferred redirect, IF/ID flush and JAL link.
module next_pc_unit #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [5:0]      OP_BEQ   = cpu_defs_pkg::OP_BEQ,
  parameter logic [5:0]      OP_J     = cpu_defs_pkg::OP_J,
  parameter logic [5:0]      OP_JAL   = cpu_defs_pkg::OP_JAL,
  parameter logic [5:0]      OP_RTYPE = cpu_defs_pkg::OP_RTYPE,
  parameter logic [5:0]      FUNCT_JR = cpu_defs_pkg::FUNCT_JR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic [WIDTH-1:0] id_pc4,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] reg_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             flush,
  output logic [WIDTH-1:0] link_addr,
  output logic             link_valid,
  output logic             redirect_pending
);
  import cpu_defs_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [WIDTH-1:0] link_addr_q, link_addr_d;
  logic             link_valid_q, link_valid_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [WIDTH-1:0] pend_pc4_q, pend_pc4_d;
  logic             pend_jal_q, pend_jal_d;

  kind_e            kind;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             is_jal;

  pc_redirect_decode #(
    .WIDTH    (WIDTH),
    .OP_BEQ   (OP_BEQ),
    .OP_J     (OP_J),
    .OP_JAL   (OP_JAL),
    .OP_RTYPE (OP_RTYPE),
    .FUNCT_JR (FUNCT_JR)
  ) u_dec (
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .reg_target    (reg_target),
    .kind          (kind),
    .redirect      (redirect),
    .target        (target)
  );

  assign is_jal   = (kind == K_JMP) && (opcode == OP_JAL);
  assign pc_plus4 = pc_q + WIDTH'(4);

  assign pc               = pc_q;
  assign flush            = flush_q;
  assign link_addr        = link_addr_q;
  assign link_valid       = link_valid_q;
  assign redirect_pending = (state_q == ST_HOLD);

  // Next PC, FSM transition, pending capture and link
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_d      = 1'b0;
    link_addr_d  = link_addr_q;
    link_valid_d = 1'b0;
    pend_tgt_d   = pend_tgt_q;
    pend_pc4_d   = pend_pc4_q;
    pend_jal_d   = pend_jal_q;
    unique case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (redirect) begin
            pc_d    = target;
            flush_d = 1'b1;
            if (is_jal) begin
              link_addr_d  = id_pc4 + WIDTH'(4);
              link_valid_d = 1'b1;
            end
          end else begin
            pc_d = pc_plus4;
          end
        end else if (redirect) begin
          state_d    = ST_HOLD;
          pend_tgt_d = target;
          pend_pc4_d = id_pc4;
          pend_jal_d = is_jal;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          state_d = ST_RUN;
          pc_d    = pend_tgt_q;
          flush_d = 1'b1;
          if (pend_jal_q) begin
            link_addr_d  = pend_pc4_q + WIDTH'(4);
            link_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      flush_q      <= 1'b0;
      link_addr_q  <= '0;
      link_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
      pend_pc4_q   <= '0;
      pend_jal_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_q      <= flush_d;
      link_addr_q  <= link_addr_d;
      link_valid_q <= link_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_pc4_q   <= pend_pc4_d;
      pend_jal_q   <= pend_jal_d;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: reference model feeds
// an expectation queue checked after each edge.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [5:0]  opcode = 6'h23;
  logic [5:0]  funct = 6'h00;
  logic        zero = 1'b0;
  logic [31:0] id_pc4 = '0;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] reg_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic [31:0] link_addr;
  logic        link_valid;
  logic        redirect_pending;

  next_pc_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .opcode           (opcode),
    .funct            (funct),
    .zero             (zero),
    .id_pc4           (id_pc4),
    .branch_target    (branch_target),
    .jump_target      (jump_target),
    .reg_target       (reg_target),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .flush            (flush),
    .link_addr        (link_addr),
    .link_valid       (link_valid),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] la;
    logic        fl;
    logic        lv;
    logic        pend;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad = 0;

  logic [31:0] m_pc = '0;
  logic [31:0] m_la = '0;
  logic        m_fl = 1'b0;
  logic        m_lv = 1'b0;
  logic        m_hold = 1'b0;
  logic [31:0] m_ptgt = '0;
  logic [31:0] m_ppc4 = '0;
  logic        m_pjal = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model();
    logic        red;
    logic        jal;
    logic [31:0] tgt;
    red = 1'b0;
    jal = 1'b0;
    tgt = '0;
    if (opcode == 6'h00 && funct == 6'h08) begin
      red = 1'b1;
      tgt = reg_target;
    end else if (opcode == 6'h02 || opcode == 6'h03) begin
      red = 1'b1;
      tgt = jump_target;
      jal = (opcode == 6'h03);
    end else if (opcode == 6'h04 && zero) begin
      red = 1'b1;
      tgt = branch_target;
    end
    if (rst) begin
      m_pc = '0; m_la = '0; m_fl = 0; m_lv = 0;
      m_hold = 0; m_ptgt = '0; m_ppc4 = '0; m_pjal = 0;
      return;
    end
    m_lv = 1'b0;
    m_fl = 1'b0;
    if (m_hold) begin
      if (!stall) begin
        m_pc = m_ptgt;
        m_fl = 1'b1;
        m_hold = 1'b0;
        if (m_pjal) begin
          m_la = m_ppc4 + 32'd4;
          m_lv = 1'b1;
        end
      end
    end else if (stall) begin
      if (red) begin
        m_hold = 1'b1;
        m_ptgt = tgt;
        m_ppc4 = id_pc4;
        m_pjal = jal;
      end
    end else if (red) begin
      m_pc = tgt;
      m_fl = 1'b1;
      if (jal) begin
        m_la = id_pc4 + 32'd4;
        m_lv = 1'b1;
      end
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    exp_t e;
    model();
    e.pc = m_pc; e.la = m_la; e.fl = m_fl;
    e.lv = m_lv; e.pend = m_hold;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pc", pc, e.pc);
    chk("pc4", pc_plus4, e.pc + 32'd4);
    chk("flush", {31'd0, flush}, {31'd0, e.fl});
    chk("lvalid", {31'd0, link_valid}, {31'd0, e.lv});
    chk("laddr", link_addr, e.la);
    chk("pend", {31'd0, redirect_pending}, {31'd0, e.pend});
  endtask

  task automatic set(input logic [5:0] op, input logic s);
    opcode = op;
    stall  = s;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    chk("rst_pc", pc, 32'h0);
    rst = 1'b0;
    set(6'h23, 0);
    tick(); chk("seq1", pc, 32'h4);
    tick(); chk("seq2", pc, 32'h8);
    tick(); chk("seq3", pc, 32'hC);
    tick(); chk("seq4", pc, 32'h10);
    set(6'h04, 0); zero = 1; branch_target = 32'h40;
    tick(); chk("beq_t", pc, 32'h40);
    chk("beq_fl", {31'd0, flush}, 32'd1);
    set(6'h23, 0);
    tick(); chk("beq_fl1", {31'd0, flush}, 32'd0);
    set(6'h04, 0); zero = 0;
    tick(); chk("beq_nt", pc, 32'h48);
    set(6'h03, 0); jump_target = 32'h100; id_pc4 = 32'h24;
    tick(); chk("jal_pc", pc, 32'h100);
    chk("jal_la", link_addr, 32'h28);
    set(6'h23, 0);
    tick(); chk("jal_lv0", {31'd0, link_valid}, 32'd0);
    set(6'h00, 0); funct = 6'h08; reg_target = 32'h28;
    tick(); chk("jr_pc", pc, 32'h28);
    funct = 6'h00;
    set(6'h02, 1); jump_target = 32'h200;
    tick(); chk("hold_pend", {31'd0, redirect_pending}, 32'd1);
    jump_target = 32'h300;
    tick();
    tick(); chk("hold_pc", pc, 32'h28);
    set(6'h02, 0);
    tick(); chk("rel_pc", pc, 32'h200);
    chk("rel_fl", {31'd0, flush}, 32'd1);
    set(6'h04, 1); zero = 0;
    tick();
    set(6'h03, 1); jump_target = 32'h500; id_pc4 = 32'h60;
    tick();
    id_pc4 = 32'h80; jump_target = 32'h700;
    tick();
    set(6'h23, 0);
    tick(); chk("hjal_pc", pc, 32'h500);
    chk("hjal_la", link_addr, 32'h64);
    chk("hjal_lv", {31'd0, link_valid}, 32'd1);
    set(6'h00, 0); funct = 6'h08; reg_target = 32'hFFFF_FFFC;
    tick(); chk("wrap_p4", pc_plus4, 32'h0);
    funct = 6'h00;
    set(6'h23, 0);
    tick(); chk("wrap_pc", pc, 32'h0);
    set(6'h02, 1); jump_target = 32'h900;
    tick();
    rst = 1'b1;
    tick(); chk("hrst_pc", pc, 32'h0);
    chk("hrst_pend", {31'd0, redirect_pending}, 32'd0);
    rst = 1'b0;
    set(6'h23, 0);
    tick(); chk("post_rst", pc, 32'h4);
    chk("post_fl", {31'd0, flush}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      stall = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: begin opcode = 6'h04; zero = 1'($urandom_range(0, 1)); end
        1: opcode = 6'h02;
        2: opcode = 6'h03;
        3: begin opcode = 6'h00; funct = 6'h08; end
        default: opcode = 6'h23;
      endcase
      id_pc4        = {$urandom_range(0, 255), 2'b00};
      branch_target = {$urandom_range(0, 255), 2'b00};
      jump_target   = {$urandom_range(0, 255), 2'b00};
      reg_target    = {$urandom_range(0, 255), 2'b00};
      tick();
      funct = 6'h00;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
